// File: rtl/i2c_target.sv
// I2C target: START/STOP detection, 7-bit address match, 1- or 2-byte writes
// reported at STOP, and MSB-byte-first reads of tx_data. SCL/SDA are
// oversampled on clk through a synchroniser chain.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bus free, waiting for START
// ADDR      | shifting in 7 address bits + R/W
// ADDR_ACK  | driving address ACK through the 9th clock
// WR_BYTE   | shifting in a write data byte
// WR_ACK    | driving data ACK through the 9th clock
// RD_BYTE   | driving a read data byte, one bit per SCL low phase
// RD_ACK    | SDA released, sampling master ACK/NACK
// WAIT_STOP | not addressed or transfer ended; only START/STOP leave
module i2c_target #(
   parameter logic [6:0] ADDR        = 7'h48,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_out,
   input  logic [15:0] tx_data,
   output logic        tx_taken,
   output logic [15:0] rx_data,
   output logic [1:0]  rx_len,
   output logic        rx_valid,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR_ST, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
   } state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic                   scl_prev_q, sda_prev_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic [7:0]  tx_low_q, tx_low_d;
   logic        rw_q, rw_d;
   logic        ack_q, ack_d;
   logic        sda_out_q, sda_out_d;
   logic        tx_taken_q, tx_taken_d;
   logic [15:0] rx_data_q, rx_data_d;
   logic [1:0]  rx_len_q, rx_len_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  next_byte;
   logic [1:0]  byte_cnt_inc;

   assign scl_s = scl_sync_q[SYNC_STAGES-1];
   assign sda_s = sda_sync_q[SYNC_STAGES-1];

   // Conditions are judged on the two most recent synchronised samples.
   assign scl_rise  = scl_s & ~scl_prev_q;
   assign scl_fall  = ~scl_s & scl_prev_q;
   assign start_det = scl_s & sda_prev_q & ~sda_s;
   assign stop_det  = scl_s & ~sda_prev_q & sda_s;

   assign byte_cnt_inc = (byte_cnt_q == 2'd3) ? 2'd3 : byte_cnt_q + 2'd1;
   // Only two bytes of tx_data exist; further read bytes leave the bus released.
   assign next_byte    = (byte_cnt_q == 2'd1) ? tx_low_q : 8'hFF;

   // Synchronise the bus lines and keep the previous synced sample for edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
         scl_prev_q <= scl_s;
         sda_prev_q <= sda_s;
      end
   end

   // State and datapath registers; reset releases SDA immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         byte_cnt_q <= 2'd0;
         shift_q    <= 8'h00;
         tx_shift_q <= 8'hFF;
         tx_low_q   <= 8'h00;
         rw_q       <= 1'b1;
         ack_q      <= 1'b1;
         sda_out_q  <= 1'b1;
         tx_taken_q <= 1'b0;
         rx_data_q  <= 16'h0000;
         rx_len_q   <= 2'd0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         tx_shift_q <= tx_shift_d;
         tx_low_q   <= tx_low_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         sda_out_q  <= sda_out_d;
         tx_taken_q <= tx_taken_d;
         rx_data_q  <= rx_data_d;
         rx_len_q   <= rx_len_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   // Next-state logic: STOP beats everything, then START, then bit handling.
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      tx_shift_d = tx_shift_q;
      tx_low_d   = tx_low_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      sda_out_d  = sda_out_q;
      tx_taken_d = 1'b0;
      rx_data_d  = rx_data_q;
      rx_len_d   = rx_len_q;
      rx_valid_d = 1'b0;

      if (stop_det) begin
         state_d   = IDLE;
         sda_out_d = 1'b1;
         if (!rw_q && byte_cnt_q != 2'd0) begin
            rx_valid_d = 1'b1;
            if (byte_cnt_q == 2'd1) begin
               // The single byte was parked in the high half; move it down.
               rx_len_d  = 2'd1;
               rx_data_d = {8'h00, rx_data_q[15:8]};
            end else begin
               rx_len_d = 2'd2;
            end
         end
      end else if (start_det) begin
         state_d    = ADDR_ST;
         bit_cnt_d  = 4'd0;
         byte_cnt_d = 2'd0;
         sda_out_d  = 1'b1;
         rx_data_d  = 16'h0000;
         rw_d       = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               sda_out_d = 1'b1;
            end
            ADDR_ST: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd0;
                  rw_d      = shift_q[0];
                  if (shift_q[7:1] == ADDR) begin
                     sda_out_d = 1'b0;
                     state_d   = ADDR_ACK;
                  end else begin
                     sda_out_d = 1'b1;
                     state_d   = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  if (!rw_q) begin
                     sda_out_d = 1'b1;
                     state_d   = WR_BYTE;
                  end else begin
                     tx_low_d   = tx_data[7:0];
                     tx_shift_d = tx_data[15:8];
                     tx_taken_d = 1'b1;
                     sda_out_d  = tx_data[15];
                     byte_cnt_d = 2'd1;
                     state_d    = RD_BYTE;
                  end
               end
            end
            WR_BYTE: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d  = 4'd0;
                  byte_cnt_d = byte_cnt_inc;
                  if (byte_cnt_q < 2'd2) begin
                     if (byte_cnt_q == 2'd0) rx_data_d[15:8] = shift_q;
                     else                    rx_data_d[7:0]  = shift_q;
                     sda_out_d = 1'b0;
                     state_d   = WR_ACK;
                  end else begin
                     sda_out_d = 1'b1;
                     state_d   = WAIT_STOP;
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  sda_out_d = 1'b1;
                  state_d   = WR_BYTE;
               end
            end
            RD_BYTE: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     bit_cnt_d = 4'd0;
                     sda_out_d = 1'b1;
                     state_d   = RD_ACK;
                  end else if (bit_cnt_q != 4'd0) begin
                     tx_shift_d = {tx_shift_q[6:0], 1'b1};
                     sda_out_d  = tx_shift_q[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  ack_d = sda_s;
               end else if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  if (!ack_q) begin
                     tx_shift_d = next_byte;
                     sda_out_d  = next_byte[7];
                     byte_cnt_d = byte_cnt_inc;
                     state_d    = RD_BYTE;
                  end else begin
                     sda_out_d = 1'b1;
                     state_d   = WAIT_STOP;
                  end
               end
            end
            WAIT_STOP: begin
               sda_out_d = 1'b1;
            end
            default: begin
               sda_out_d = 1'b1;
               state_d   = IDLE;
            end
         endcase
      end
   end

   assign sda_out  = sda_out_q;
   assign tx_taken = tx_taken_q;
   assign rx_data  = rx_data_q;
   assign rx_len   = rx_len_q;
   assign rx_valid = rx_valid_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a simple bus master drives SCL/SDA with
// wired-AND SDA, and monitors count pulses and SDA activity on negedge clk.
module tb_i2c_target;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        scl = 1'b1;
   logic        sda_m = 1'b1;
   logic [15:0] tx_data = 16'h0000;
   logic        sda_out, tx_taken, rx_valid, busy;
   logic [15:0] rx_data;
   logic [1:0]  rx_len;
   logic        sda_bus;

   assign sda_bus = sda_m & sda_out;

   i2c_target #(.ADDR(7'h48), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl),
      .sda_in   (sda_bus),
      .sda_out  (sda_out),
      .tx_data  (tx_data),
      .tx_taken (tx_taken),
      .rx_data  (rx_data),
      .rx_len   (rx_len),
      .rx_valid (rx_valid),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad = 0;
   int          valid_cnt = 0;
   int          taken_cnt = 0;
   int          sda_low_cnt = 0;
   int          hold_viol = 0;
   logic [15:0] cap_data = 16'h0000;
   logic [1:0]  cap_len = 2'd0;
   logic        prev_scl = 1'b1;
   logic        prev_sda_out = 1'b1;

   // Pulse counters, capture at rx_valid, and SDA-stable-while-SCL-high watch.
   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt = valid_cnt + 1;
         cap_data  = rx_data;
         cap_len   = rx_len;
      end
      if (tx_taken) taken_cnt = taken_cnt + 1;
      if (!sda_out) sda_low_cnt = sda_low_cnt + 1;
      if (!rst && scl && prev_scl && sda_out !== prev_sda_out) hold_viol = hold_viol + 1;
      prev_scl     = scl;
      prev_sda_out = sda_out;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total = total + 1;
      assert (obs === exp) else begin
         bad = bad + 1;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic bit_xfer(input logic b, output logic s);
      sda_m = b;
      #50 scl = 1'b1;
      #50 s = sda_bus;
      #50 scl = 1'b0;
      #50;
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
      bit_xfer(1'b1, ack);
   endtask

   task automatic rd_byte(input logic ackbit, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, s);
         d[i] = s;
      end
      bit_xfer(ackbit, s);
   endtask

   // Works both from an idle bus and as a repeated START with SCL low.
   task automatic start_c();
      sda_m = 1'b1;
      #50 scl = 1'b1;
      #50 sda_m = 1'b0;
      #50 scl = 1'b0;
      #50;
   endtask

   task automatic stop_c();
      sda_m = 1'b0;
      #50 scl = 1'b1;
      #50 sda_m = 1'b1;
      #100;
   endtask

   initial begin
      logic       a;
      logic [7:0] d;
      int         v0, t0, l0;

      // Reset values
      #20;
      chk("rst_sda_out", 16'(sda_out), 16'd1);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_rx_data", rx_data, 16'h0000);
      chk("rst_rx_len", 16'(rx_len), 16'd0);
      chk("rst_rx_valid", 16'(rx_valid), 16'd0);
      chk("rst_tx_taken", 16'(tx_taken), 16'd0);
      rst = 1'b0;
      #40;

      // Two-byte write
      v0 = valid_cnt;
      start_c();
      wr_byte(8'h90, a); chk("w2_addr_ack", 16'(a), 16'd0);
      chk("w2_busy", 16'(busy), 16'd1);
      wr_byte(8'hBE, a); chk("w2_b1_ack", 16'(a), 16'd0);
      wr_byte(8'hEF, a); chk("w2_b2_ack", 16'(a), 16'd0);
      stop_c();
      chk("w2_valid_pulses", 16'(valid_cnt - v0), 16'd1);
      chk("w2_cap_data", cap_data, 16'hBEEF);
      chk("w2_cap_len", 16'(cap_len), 16'd2);
      chk("w2_rx_data_hold", rx_data, 16'hBEEF);
      chk("w2_busy_after", 16'(busy), 16'd0);

      // One-byte write
      v0 = valid_cnt;
      start_c();
      wr_byte(8'h90, a); chk("w1_addr_ack", 16'(a), 16'd0);
      wr_byte(8'h5A, a); chk("w1_b1_ack", 16'(a), 16'd0);
      stop_c();
      chk("w1_valid_pulses", 16'(valid_cnt - v0), 16'd1);
      chk("w1_cap_data", cap_data, 16'h005A);
      chk("w1_cap_len", 16'(cap_len), 16'd1);

      // Three-byte write: third byte NACKed, first two reported
      v0 = valid_cnt;
      start_c();
      wr_byte(8'h90, a); chk("w3_addr_ack", 16'(a), 16'd0);
      wr_byte(8'h11, a); chk("w3_b1_ack", 16'(a), 16'd0);
      wr_byte(8'h22, a); chk("w3_b2_ack", 16'(a), 16'd0);
      wr_byte(8'h33, a); chk("w3_b3_nack", 16'(a), 16'd1);
      stop_c();
      chk("w3_valid_pulses", 16'(valid_cnt - v0), 16'd1);
      chk("w3_cap_data", cap_data, 16'h1122);
      chk("w3_cap_len", 16'(cap_len), 16'd2);

      // Two-byte read, master NACKs the second byte
      tx_data = 16'hA55A;
      v0 = valid_cnt; t0 = taken_cnt;
      start_c();
      wr_byte(8'h91, a); chk("rd_addr_ack", 16'(a), 16'd0);
      rd_byte(1'b0, d);  chk("rd_byte1", 16'(d), 16'h00A5);
      rd_byte(1'b1, d);  chk("rd_byte2", 16'(d), 16'h005A);
      chk("rd_sda_released", 16'(sda_out), 16'd1);
      stop_c();
      chk("rd_busy_after", 16'(busy), 16'd0);
      chk("rd_taken_pulses", 16'(taken_cnt - t0), 16'd1);
      chk("rd_no_valid", 16'(valid_cnt - v0), 16'd0);

      // Address mismatch: target stays silent
      v0 = valid_cnt; t0 = taken_cnt; l0 = sda_low_cnt;
      start_c();
      wr_byte(8'h92, a); chk("nm_addr_nack", 16'(a), 16'd1);
      wr_byte(8'h55, a); chk("nm_data_nack", 16'(a), 16'd1);
      chk("nm_busy_frame", 16'(busy), 16'd1);
      stop_c();
      chk("nm_busy_after", 16'(busy), 16'd0);
      chk("nm_sda_low_cycles", 16'(sda_low_cnt - l0), 16'd0);
      chk("nm_no_valid", 16'(valid_cnt - v0), 16'd0);
      chk("nm_no_taken", 16'(taken_cnt - t0), 16'd0);

      // Repeated START: write cancelled, then read
      tx_data = 16'h3C00;
      v0 = valid_cnt; t0 = taken_cnt;
      start_c();
      wr_byte(8'h90, a); chk("rs_waddr_ack", 16'(a), 16'd0);
      wr_byte(8'h12, a); chk("rs_wdata_ack", 16'(a), 16'd0);
      start_c();
      chk("rs_rx_cleared", rx_data, 16'h0000);
      wr_byte(8'h91, a); chk("rs_raddr_ack", 16'(a), 16'd0);
      rd_byte(1'b1, d);  chk("rs_rd_byte1", 16'(d), 16'h003C);
      stop_c();
      chk("rs_no_valid", 16'(valid_cnt - v0), 16'd0);
      chk("rs_taken_pulses", 16'(taken_cnt - t0), 16'd1);

      // Reset while driving a 0 read bit
      tx_data = 16'h00FF;
      v0 = valid_cnt;
      start_c();
      wr_byte(8'h91, a); chk("rr_addr_ack", 16'(a), 16'd0);
      chk("rr_driving_zero", 16'(sda_out), 16'd0);
      rst = 1'b1;
      #1;
      chk("rr_async_release", 16'(sda_out), 16'd1);
      chk("rr_busy_reset", 16'(busy), 16'd0);
      #29 rst = 1'b0;
      sda_m = 1'b1;
      scl = 1'b1;
      #100;
      chk("rr_no_valid", 16'(valid_cnt - v0), 16'd0);
      v0 = valid_cnt;
      start_c();
      wr_byte(8'h90, a); chk("rr_waddr_ack", 16'(a), 16'd0);
      wr_byte(8'h01, a); chk("rr_wdata_ack", 16'(a), 16'd0);
      stop_c();
      chk("rr_valid_pulses", 16'(valid_cnt - v0), 16'd1);
      chk("rr_cap_data", cap_data, 16'h0001);
      chk("rr_cap_len", 16'(cap_len), 16'd1);

      chk("sda_stable_scl_high", 16'(hold_viol), 16'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) that answers the team's I2C master: recognises START/STOP, matches a 7-bit address, ACKs, and handles 1- or 2-byte transfers.
- Writes: received bytes are assembled MSB-byte-first into rx_data and reported at STOP.
- Reads: tx_data is returned MSB-byte-first.
- Runs on a local system clock that oversamples SCL/SDA; used as a bus-functional peripheral and as the master's loopback partner.

Parameters:
ADDR, 7'h48, own 7-bit target address
SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in (min 2)

Ports:
clk  input  1  system clock; must be >= 8x SCL frequency
rst  input  1  reset
scl_in  input  1  bus SCL level
sda_in  input  1  bus SDA level
sda_out  output  1  open-drain drive: 0 = pull SDA low, 1 = release
tx_data  input  16  read data; [15:8] sent first, [7:0] second
tx_taken  output  1  one-cycle pulse when tx_data is latched
rx_data  output  16  write data; 1-byte write lands in [7:0] with [15:8]=0
rx_len  output  2  bytes received in the last write (1 or 2)
rx_valid  output  1  one-cycle pulse at STOP after a write of >=1 byte
busy  output  1  high when state != IDLE

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk.
- Reset values: sda_out=1, tx_taken=0, rx_valid=0, rx_data=0, rx_len=0, busy=0, state=IDLE, synchronisers=1.
- Inputs pass through SYNC_STAGES flops. Edge detection compares the last two synced samples.
  - START: synced SDA 1->0 while synced SCL=1.
  - STOP: synced SDA 0->1 while synced SCL=1.
- Bit timing:
  - Data sampled on synced SCL rising edge.
  - sda_out updated on the clk cycle after a synced SCL falling edge is detected.
  - sda_out never changes while synced SCL=1.
- START from any state, including repeated START: enter ADDR, bit counter=0, byte counter=0, sda_out=1, rx_data cleared.
- STOP from any state: enter IDLE, sda_out=1. If the transfer was a write with byte counter >=1, pulse rx_valid for one cycle and set rx_len = min(byte counter, 2).
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, MSB first (7 address bits + R/W). After the 8th falling edge:
    - Address matches ADDR: drive sda_out=0 (ACK) and go to ADDR_ACK.
    - No match: go to WAIT_STOP, sda released.
  - ADDR_ACK: ACK held through the 9th SCL high. On the 9th falling edge:
    - Write (R/W=0): release SDA, go to WR_BYTE.
    - Read (R/W=1): latch tx_data, pulse tx_taken, drive bit 15 (sda_out = bit value), go to RD_BYTE.
  - WR_BYTE: shift 8 bits into the byte register. After the 8th falling edge:
    - byte counter < 2: store byte (first byte -> rx_data[15:8] provisionally), increment byte counter, ACK, go to WR_ACK.
    - byte counter = 2: leave SDA released (NACK), go to WAIT_STOP.
    - At STOP with byte counter = 1, the stored byte is moved to rx_data[7:0] and [15:8] cleared.
  - WR_ACK: on the 9th falling edge, release SDA and return to WR_BYTE.
  - RD_BYTE: drive the next bit after each falling edge. After the 8th falling edge, release SDA and go to RD_ACK.
    - Byte 1 = latched[15:8], byte 2 = latched[7:0].
    - Byte 3 and later = 8'hFF (SDA released).
  - RD_ACK: sample master ACK on the 9th rising edge.
    - 0: on the 9th falling edge drive the MSB of the next byte, go to RD_BYTE.
    - 1 (NACK): release SDA, go to WAIT_STOP.
  - WAIT_STOP: SDA released; only START or STOP exits.
- Bit counter is 4 bits and wraps to 0 at each byte boundary. Byte counter is 2 bits and saturates at 3.
- START and STOP cannot coincide. If STOP is detected on the same cycle as an SCL edge, STOP wins.
- rst mid-transfer: SDA is released within the same cycle (async). No rx_valid is produced.

Test Plan:
- Write 2 bytes: START, 0x90 (addr 0x48, W), 0xBE, 0xEF, STOP -> three ACKs (SDA=0 on 9th SCL), rx_valid single pulse, rx_data=16'hBEEF, rx_len=2.
- Write 1 byte: START, 0x90, 0x5A, STOP -> rx_data=16'h005A, rx_len=1. Third byte in a separate 3-byte write is NACKed (SDA=1 on 9th SCL).
- Read 2 bytes: tx_data=16'hA55A; START, 0x91, master ACKs byte 1 and NACKs byte 2 -> tx_taken one pulse, bus bytes 0xA5 then 0x5A, SDA released after NACK, busy=0 after STOP, no rx_valid.
- Address mismatch: START, 0x92 (addr 0x49) -> SDA stays 1 for the whole frame, no rx_valid/tx_taken, busy=1 until STOP.
- Repeated START: write 0x90, 0x12, then repeated START 0x91 and read with tx_data=16'h3C00 -> ACKs correct, first read byte 0x3C, no rx_valid (write cancelled by re-START).
- Reset mid-read while driving a 0 bit -> sda_out=1 immediately; next START 0x90 + 0x01 + STOP gives rx_data=16'h0001.
